// File: rtl/hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_ctrl : forwarding select, load-use stall and branch-penalty FSM.  |
// | Optional HAZARD_STATS_EN adds saturating stall counters.  Rev 1.0        |
// +--------------------------------------------------------------------------+
module hazard_ctrl #(
   parameter int NFWD   = 3,
   parameter int AW     = 5,
   parameter int BR_PEN = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              dmem_wait,
   input  logic              imem_wait,
   input  logic [NFWD-1:0]   src_we,
   input  logic [NFWD*AW-1:0] src_wa,
   input  logic              ex_memread,
   input  logic [AW-1:0]     rs,
   input  logic [AW-1:0]     rt,
   input  logic              uses_rt,
   input  logic              branch_id,
   output logic              PCWrite,
   output logic              IFIDWrite,
   output logic              Hazard,
   output logic              pipe_en,
   output logic              imem_en,
   output logic [2:0]        fwd_a,
`ifdef HAZARD_STATS_EN
   output logic [15:0]       stat_lu,
   output logic [15:0]       stat_br,
   output logic [15:0]       stat_wait,
`endif
   output logic [2:0]        fwd_b
);

   typedef enum logic {RUN = 1'b0, BRANCH = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic          w_lu;
   logic          w_mem_wait;
   logic [AW-1:0] w_ex_wa;

   assign w_ex_wa    = src_wa[AW-1:0];
   assign w_mem_wait = dmem_wait | imem_wait;
   assign w_lu       = ex_memread && src_we[0] && (w_ex_wa != '0) &&
                       ((w_ex_wa == rs) || (uses_rt && (w_ex_wa == rt)));

   // Scan oldest to youngest so the youngest matching source wins.
   always_comb begin
      fwd_a = 3'd0;
      fwd_b = 3'd0;
      for (int i = NFWD - 1; i >= 0; i--) begin
         if (src_we[i] && (src_wa[i*AW +: AW] == rs) && (rs != '0))
            fwd_a = 3'(i + 1);
         if (uses_rt && src_we[i] && (src_wa[i*AW +: AW] == rt) && (rt != '0))
            fwd_b = 3'(i + 1);
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      pipe_en   = 1'b0;
      imem_en   = 1'b0;
      Hazard    = (state_q == BRANCH);
      if (rst) begin
         Hazard = 1'b0;
      end else if (!enable) begin
         Hazard = (state_q == BRANCH);
      end else if (w_mem_wait) begin
         imem_en = !dmem_wait;
      end else if (state_q == BRANCH) begin
         Hazard  = 1'b1;
         pipe_en = 1'b1;
         PCWrite = (cnt_q == 3'd1);
         imem_en = (cnt_q == 3'd1);
         if (cnt_q <= 3'd1) begin
            cnt_d   = 3'd0;
            state_d = RUN;
         end else begin
            cnt_d = cnt_q - 3'd1;
         end
      end else if (w_lu) begin
         Hazard  = 1'b1;
         pipe_en = 1'b1;
      end else if (branch_id) begin
         IFIDWrite = 1'b1;
         pipe_en   = 1'b1;
         state_d   = BRANCH;
         cnt_d     = 3'(BR_PEN);
      end else begin
         PCWrite   = 1'b1;
         IFIDWrite = 1'b1;
         pipe_en   = 1'b1;
         imem_en   = 1'b1;
         Hazard    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef HAZARD_STATS_EN
   logic        w_active;
   logic [15:0] stat_lu_q, stat_lu_d;
   logic [15:0] stat_br_q, stat_br_d;
   logic [15:0] stat_wait_q, stat_wait_d;

   assign w_active = !rst && enable;

   // Counters stick at all-ones instead of wrapping.
   always_comb begin
      stat_lu_d   = stat_lu_q;
      stat_br_d   = stat_br_q;
      stat_wait_d = stat_wait_q;
      if (w_active && w_mem_wait && (stat_wait_q != 16'hFFFF))
         stat_wait_d = stat_wait_q + 16'd1;
      if (w_active && !w_mem_wait && (state_q == BRANCH) && (stat_br_q != 16'hFFFF))
         stat_br_d = stat_br_q + 16'd1;
      if (w_active && !w_mem_wait && (state_q == RUN) && w_lu && (stat_lu_q != 16'hFFFF))
         stat_lu_d = stat_lu_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_lu_q   <= 16'd0;
         stat_br_q   <= 16'd0;
         stat_wait_q <= 16'd0;
      end else begin
         stat_lu_q   <= stat_lu_d;
         stat_br_q   <= stat_br_d;
         stat_wait_q <= stat_wait_d;
      end
   end

   assign stat_lu   = stat_lu_q;
   assign stat_br   = stat_br_q;
   assign stat_wait = stat_wait_q;
`endif

endmodule
`default_nettype wire
